fft_bitrev_reorder: RTL and testbench

Output-side companion of the `dit` FFT core. It receives the core's bit-reversed-order result stream, with the same `nd`/`m`/`first` framing the core produces, and re-emits each N-point frame in natural bin order with a regenerated `first` flag. Frames are double-buffered in two banks, so a continuous back-to-back stream passes through without stalls. It sits directly after `dit` in the datapath and is driven from the same myhdl-wrapped test environment.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_buffer_bank.sv | 32 +++
 rtl/fft_bitrev_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT output reorder path.
//   wstate_t : write-side framing FSM encoding (SYNC, FILL)
//   bitrev   : reverse the low log_n bits of k (log_n is a constant at use sites)
package fft_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    FILL = 1'b1
  } wstate_t;

  function automatic logic [15:0] bitrev(input logic [15:0] k, input int log_n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < log_n; i++) r[i] = k[log_n-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_buffer_bank.sv
// fft_buffer_bank: simple dual-port RAM backing both reorder banks.
//   clk, rst_n : clock, async active-low reset (output register only)
//   we, waddr, wdata : write port, address {bank, index}
//   re, raddr, rdata : registered read port; rdata updates on re, holds otherwise
// Array contents are intentionally not reset.
module fft_buffer_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: turns the bit-reversed output stream of the dit FFT core
// into natural-order frames, double-buffered so back-to-back frames never stall.
//   clk, rst_n           : clock, async active-low reset
//   in_data/in_nd/in_m/in_first  : bit-reversed sample stream with framing
//   out_data/out_nd/out_m/out_first : natural-order stream, out_first on bin 0
//   error                : sticky framing error
// Write side: SYNC/FILL FSM scattering sample k to index bitrev(k) of bank wb.
// Read side: a full bank is swept 0..N-1 through a 2-stage pipe
// (address register, then RAM output register).
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N       = 8,
  parameter int LOG_N   = 3,
  parameter int X_WIDTH = 16,
  parameter int MWIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*X_WIDTH-1:0] in_data,
  input  logic                 in_nd,
  input  logic [MWIDTH-1:0]    in_m,
  input  logic                 in_first,
  output logic [2*X_WIDTH-1:0] out_data,
  output logic                 out_nd,
  output logic [MWIDTH-1:0]    out_m,
  output logic                 out_first,
  output logic                 error
);

  localparam int W      = 2*X_WIDTH + MWIDTH;
  localparam int AW     = LOG_N + 1;
  localparam int STAGES = 2;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N-1);

  // ---------------- write side ----------------
  wstate_t          state, nxt_state;
  logic [LOG_N-1:0] wcnt, nxt_wcnt, widx;
  logic             wb, nxt_wb, we, set_full, set_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      wcnt  <= '0;
      wb    <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt_state;
      wcnt  <= nxt_wcnt;
      wb    <= nxt_wb;
      error <= error | set_err;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_wcnt  = wcnt;
    nxt_wb    = wb;
    we        = 1'b0;
    widx      = '0;
    set_full  = 1'b0;
    set_err   = 1'b0;
    if (in_nd) begin
      unique case (state)
        SYNC: begin
          if (in_first) begin
            we        = 1'b1;
            nxt_wcnt  = LOG_N'(1);
            nxt_state = FILL;
          end else begin
            set_err = 1'b1;
          end
        end
        FILL: begin
          if (in_first) begin
            // restart in the same bank; any partial frame is simply overwritten
            set_err  = (wcnt != '0);
            we       = 1'b1;
            nxt_wcnt = LOG_N'(1);
          end else if (wcnt == '0) begin
            set_err   = 1'b1;
            nxt_state = SYNC;
          end else begin
            we   = 1'b1;
            widx = LOG_N'(bitrev(16'(wcnt), LOG_N));
            if (wcnt == LAST) begin
              set_full = 1'b1;
              nxt_wb   = ~wb;
              nxt_wcnt = '0;
            end else begin
              nxt_wcnt = wcnt + 1'b1;
            end
          end
        end
        default: nxt_state = SYNC;
      endcase
    end
  end

  // ---------------- read side ----------------
  logic [1:0]        full;
  logic              rb, rd_go, rd_last;
  logic [LOG_N-1:0]  rcnt;
  logic [AW-1:0]     raddr;
  logic [STAGES:1]   vld_pipe, fst_pipe;
  logic [W-1:0]      rdata;

  // a full bank stays full until its last address issues, so frames chain gap-free
  assign rd_go   = full[rb];
  assign rd_last = rd_go && (rcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      rb       <= 1'b0;
      rcnt     <= '0;
      raddr    <= '0;
      vld_pipe <= '0;
      fst_pipe <= '0;
    end else begin
      // set (writer) and clear (reader) may hit different banks in one cycle
      for (int b = 0; b < 2; b++)
        full[b] <= (full[b] && !(rd_last && (rb == 1'(b)))) || (set_full && (wb == 1'(b)));
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_go};
      fst_pipe <= {fst_pipe[STAGES-1:1], rd_go && (rcnt == '0)};
      if (rd_go) begin
        raddr <= {rb, rcnt};
        rcnt  <= rcnt + 1'b1;
        if (rd_last) rb <= ~rb;
      end
    end
  end

  fft_buffer_bank #(.DEPTH(2*N), .AW(AW), .W(W)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr ({wb, widx}),
    .wdata ({in_data, in_m}),
    .re    (vld_pipe[1]),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign out_data  = rdata[W-1:MWIDTH];
  assign out_m     = rdata[MWIDTH-1:0];
  assign out_nd    = vld_pipe[STAGES];
  assign out_first = fst_pipe[STAGES];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=8): a per-cycle vector table for a
// single frame, then captured-stream sequences for streaming and error cases.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_nd = 1'b0;
  logic [0:0]  in_m = '0;
  logic        in_first = 1'b0;
  logic [31:0] out_data;
  logic        out_nd;
  logic [0:0]  out_m;
  logic        out_first;
  logic        error;

  fft_bitrev_reorder #(.N(8), .LOG_N(3), .X_WIDTH(16), .MWIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .in_first(in_first), .out_data(out_data), .out_nd(out_nd), .out_m(out_m),
    .out_first(out_first), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit nd; bit first; logic [31:0] data; logic m;
    bit e_nd; bit e_first; logic [31:0] e_data; logic e_m; bit e_err;
  } vec_t;

  typedef struct { bit nd; bit first; logic [31:0] data; logic m; } stim_t;
  typedef struct { int c; logic [31:0] d; logic m; logic f; } cap_t;

  int    n_run = 0, n_fail = 0;
  int    bro [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  vec_t  tbl [18];
  stim_t st [$];
  cap_t  cap [$], exq [$];
  bit    errh [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input bit gap, input int cnt);
    stim_t s;
    for (int i = 0; i < cnt; i++) begin
      s.nd = 1'b1; s.first = (i == 0); s.data = base + 32'(bro[i]); s.m = bro[i][0];
      st.push_back(s);
      if (gap) begin
        s.nd = 1'b0; s.first = 1'b0;
        st.push_back(s);
      end
    end
  endtask

  task automatic push_exp(input int c, input logic [31:0] d, input int k);
    cap_t e;
    e.c = c; e.d = d; e.m = 1'(k % 2); e.f = (k % 8 == 0);
    exq.push_back(e);
  endtask

  // apply queued stimulus plus idle cycles, capturing every valid output
  task automatic drive(input int extra);
    cap_t r;
    int   len;
    len = st.size();
    cap.delete(); errh.delete();
    for (int c = 0; c < len + extra; c++) begin
      if (c < len) begin
        in_nd = st[c].nd; in_first = st[c].first; in_data = st[c].data; in_m = st[c].m;
      end else begin
        in_nd = 1'b0; in_first = 1'b0;
      end
      @(posedge clk); #1;
      errh.push_back(error);
      if (out_nd) begin
        r.c = c; r.d = out_data; r.m = out_m; r.f = out_first;
        cap.push_back(r);
      end
    end
    in_nd = 1'b0; in_first = 1'b0;
    st.delete();
  endtask

  task automatic compare(input string nm);
    chk($sformatf("%s count", nm), cap.size(), exq.size());
    for (int k = 0; k < cap.size() && k < exq.size(); k++) begin
      chk($sformatf("%s[%0d] cycle", nm, k), cap[k].c, exq[k].c);
      chk($sformatf("%s[%0d] data", nm, k), cap[k].d, exq[k].d);
      chk($sformatf("%s[%0d] first", nm, k), 32'(cap[k].f), 32'(exq[k].f));
      chk($sformatf("%s[%0d] m", nm, k), 32'(cap[k].m), 32'(exq[k].m));
    end
    exq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    chk("rst out_nd", 32'(out_nd), 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_first", 32'(out_first), 0);
    chk("rst out_m", 32'(out_m), 0);
    chk("rst error", 32'(error), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // single frame; in_m = in_data[0] so out_m must track out_data[0]
    for (int i = 0; i < 18; i++) begin
      tbl[i] = '{default: '0};
      if (i < 8) begin
        tbl[i].nd = 1'b1; tbl[i].first = (i == 0);
        tbl[i].data = 32'(bro[i]); tbl[i].m = bro[i][0];
      end
      if (i >= 9 && i <= 16) begin
        tbl[i].e_nd = 1'b1; tbl[i].e_first = (i == 9);
        tbl[i].e_data = 32'(i - 9); tbl[i].e_m = 1'((i - 9) % 2);
      end
    end

    do_reset();

    for (int i = 0; i < 18; i++) begin
      in_nd = tbl[i].nd; in_first = tbl[i].first; in_data = tbl[i].data; in_m = tbl[i].m;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_nd", i), 32'(out_nd), 32'(tbl[i].e_nd));
      chk($sformatf("vec%0d error", i), 32'(error), 32'(tbl[i].e_err));
      if (tbl[i].e_nd) begin
        chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_data);
        chk($sformatf("vec%0d out_first", i), 32'(out_first), 32'(tbl[i].e_first));
        chk($sformatf("vec%0d out_m", i), 32'(out_m), 32'(tbl[i].e_m));
      end
    end
    in_nd = 1'b0; in_first = 1'b0;

    // four back-to-back frames -> 32 contiguous outputs starting 2 after frame 0 ends
    for (int f = 0; f < 4; f++) push_frame(32'(f * 16), 1'b0, 8);
    drive(12);
    for (int k = 0; k < 32; k++) push_exp(9 + k, 32'((k / 8) * 16 + k % 8), k);
    compare("b2b");
    chk("b2b error", 32'(error), 0);

    // gapped input: frames complete at cycles 14 and 30
    push_frame(32'h200, 1'b1, 8);
    push_frame(32'h210, 1'b1, 8);
    drive(12);
    for (int k = 0; k < 16; k++)
      push_exp((k < 8) ? 16 + k : 24 + k, 32'h200 + 32'((k / 8) * 16 + k % 8), k);
    compare("gap");

    // misalignment: in_first on the 5th sample restarts the frame
    push_frame(32'h300, 1'b0, 4);
    push_frame(32'h400, 1'b0, 8);
    drive(12);
    chk("mis err before", 32'(errh[3]), 0);
    chk("mis err after", 32'(errh[4]), 1);
    for (int k = 0; k < 8; k++) push_exp(13 + k, 32'h400 + 32'(k), k);
    compare("mis");

    // startup without in_first: dropped, error raised, nothing output
    do_reset();
    begin
      stim_t s;
      for (int i = 0; i < 3; i++) begin
        s.nd = 1'b1; s.first = 1'b0; s.data = 32'h600 + 32'(i); s.m = 1'b0;
        st.push_back(s);
      end
    end
    drive(12);
    chk("startup err", 32'(errh[0]), 1);
    chk("startup count", cap.size(), 0);

    // reset pulse while a frame is being emitted and another is half written
    push_frame(32'h700, 1'b0, 8);
    push_frame(32'h710, 1'b0, 3);
    drive(0);
    chk("pre-rst out_nd", 32'(out_nd), 1);
    rst_n = 1'b0;
    #1;
    chk("async out_nd", 32'(out_nd), 0);
    chk("async error", 32'(error), 0);
    #1 rst_n = 1'b1;
    drive(12);
    chk("post-rst idle count", cap.size(), 0);
    push_frame(32'h500, 1'b0, 8);
    drive(12);
    for (int k = 0; k < 8; k++) push_exp(9 + k, 32'h500 + 32'(k), k);
    compare("clean");
    chk("clean error", 32'(error), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
